// File: rtl/uart_tx_fifo_if.sv
// Write port, flush and uart_tx handshake for uart_tx_fifo.
// master = application/uart_tx side, slave = the FIFO controller.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              flush;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              err;

  modport master (
    output wr_valid, wr_data, flush, tx_busy,
    input  wr_ready, tx_start, tx_data, level, empty, full, err
  );

  modport slave (
    input  wr_valid, wr_data, flush, tx_busy,
    output wr_ready, tx_start, tx_data, level, empty, full, err
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch controller feeding uart_tx, paced by tx_busy.
//   state     | meaning
//   IDLE      | waiting for a stored byte and an idle transmitter
//   START     | tx_start pulse high, timeout counter loaded
//   WAIT_BUSY | waiting for uart_tx to raise tx_busy (bounded)
//   WAIT_DONE | frame in progress, waiting for tx_busy to fall
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          resetn,
  uart_tx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic [CNT_W-1:0]  cnt;
  logic              wr_fire, pop, cnt_load, cnt_dec, err_set;

  assign bus.full     = (level == (ADDR_W+1)'(DEPTH));
  assign bus.empty    = (level == '0);
  assign bus.wr_ready = ~bus.full;
  assign bus.level    = level;
  // flush wins over a write presented in the same cycle
  assign wr_fire      = bus.wr_valid & ~bus.full & ~bus.flush;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.empty && !bus.tx_busy) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        cnt_load   = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt == CNT_W'(1)) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Down-counter: loaded in START, terminal count 1 ends the BUSY_TIMEOUT-th wait cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.err      <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_next;
      bus.tx_start <= (state_next == START);
      if (pop)      bus.tx_data <= mem[rd_ptr];
      if (err_set)  bus.err     <= 1'b1;
      if (cnt_load) cnt <= CNT_W'(BUSY_TIMEOUT);
      else if (cnt_dec) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= bus.wr_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue model of stored bytes plus a
// behavioural uart_tx that raises tx_busy the cycle after tx_start.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(15)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  bit mon_en = 1'b0;
  bit prev_start = 1'b0;
  int launches = 0;

  // uart_tx stand-in
  logic hold_busy = 1'b0;
  logic mbusy = 1'b0;
  bit   dead = 1'b0;
  bit   arm = 1'b0;
  bit   rand_frame = 1'b0;
  int   frame_len = 6;
  int   bcnt = 0;
  assign bus.tx_busy = hold_busy | mbusy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      mbusy = 1'b0;
      bcnt  = 0;
      arm   = 1'b0;
    end else begin
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) mbusy = 1'b0;
      end else if (arm) begin
        mbusy = 1'b1;
        bcnt  = rand_frame ? int'($urandom_range(3, 12)) : frame_len;
        arm   = 1'b0;
      end
      if (bus.tx_start && !dead) arm = 1'b1;
    end
  end

  // Monitor: every launch pops the model queue; occupancy flags follow queue size
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_start = 1'b0;
    end else begin
      if (bus.tx_start) begin
        launches++;
        chk("start_single_cycle", prev_start, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch: tx_data %0h with empty model at %0t", bus.tx_data, $time);
        end else begin
          chk("tx_data_order", bus.tx_data, exp_q.pop_front());
        end
      end
      prev_start = bus.tx_start;
      chk("level", bus.level, exp_q.size());
      chk("empty", bus.empty, exp_q.size() == 0);
      chk("full", bus.full, exp_q.size() == DEPTH);
      chk("wr_ready", bus.wr_ready, exp_q.size() != DEPTH);
    end
  end

  task automatic write_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.wr_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.wr_ready) begin
      timeout_fail("wr_ready_wait");
      return;
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    @(posedge clk);
    #1;
    exp_q.push_back(b);
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 5000) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !bus.tx_busy && !bus.tx_start) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) timeout_fail("drain");
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!bus.tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_busy) timeout_fail("busy_rise");
  endtask

  int snap;

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_err", bus.err, 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // single byte latency
    frame_len = 8;
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA5;
    @(posedge clk);
    #1;
    exp_q.push_back(8'hA5);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("lat_no_start_early", bus.tx_start, 0);
    @(negedge clk);
    chk("lat_start", bus.tx_start, 1);
    chk("lat_data", bus.tx_data, 8'hA5);
    @(negedge clk);
    chk("lat_start_drop", bus.tx_start, 0);
    drain();

    // fill with transmitter held busy, then release and wrap
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
    @(negedge clk);
    chk("fill_full", bus.full, 1);
    chk("fill_wr_ready", bus.wr_ready, 0);
    chk("fill_level", bus.level, DEPTH);
    hold_busy = 1'b0;
    drain();
    write_byte(8'h10);
    drain();

    // simultaneous write and pop
    @(negedge clk);
    hold_busy = 1'b1;
    write_byte(8'h33);
    @(negedge clk);
    hold_busy    = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h55);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("simul_start", bus.tx_start, 1);
    chk("simul_level", bus.level, 1);
    drain();

    // flush during a frame, with a write in the same cycle
    frame_len = 40;
    write_byte(8'h21);
    wait_busy();
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'h31 + 8'(i));
    @(negedge clk);
    chk("flush_pre_level", bus.level, 5);
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    @(posedge clk);
    #1;
    exp_q.delete();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("flush_level", bus.level, 0);
    chk("flush_empty", bus.empty, 1);
    snap = launches;
    hold_busy = 1'b0;
    repeat (80) @(negedge clk);
    chk("flush_no_launch", launches, snap);
    drain();

    // tx_busy never rises -> err after 15 wait cycles
    frame_len = 6;
    dead = 1'b1;
    write_byte(8'h77);
    begin
      int n = 0;
      while (!bus.tx_start && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus.tx_start) timeout_fail("timeout_launch");
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("err_not_yet", bus.err, 0);
      if (k == 16) chk("err_set", bus.err, 1);
    end
    dead = 1'b0;
    write_byte(8'h88);
    drain();
    chk("err_sticky", bus.err, 1);

    // randomized traffic
    rand_frame = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      write_byte(8'($urandom));
    end
    drain();
    rand_frame = 1'b0;

    // reset in WAIT_DONE with three bytes stored
    frame_len = 30;
    write_byte(8'h11);
    wait_busy();
    write_byte(8'h12);
    write_byte(8'h13);
    write_byte(8'h14);
    @(negedge clk);
    chk("pre_reset_level", bus.level, 3);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("reset_tx_start", bus.tx_start, 0);
    chk("reset_level", bus.level, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_wr_ready", bus.wr_ready, 1);
    chk("reset_err", bus.err, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    resetn = 1'b1;
    mon_en = 1'b1;
    snap = launches;
    repeat (60) @(negedge clk);
    chk("reset_no_launch", launches, snap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
